// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller and AluControl: states, opcodes,
// AluOp codes and the packed control word.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EX_R     = 4'd2,
        ST_WB_R     = 4'd3,
        ST_EX_I     = 4'd4,
        ST_WB_I     = 4'd5,
        ST_MEM_ADDR = 4'd6,
        ST_MEM_RD   = 4'd7,
        ST_WB_MEM   = 4'd8,
        ST_MEM_WR   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_HALT     = 4'd11
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b1000;
    localparam logic [3:0] OP_SW    = 4'b1100;
    localparam logic [3:0] OP_BEQ   = 4'b0010;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_IMM,
        CLS_MEM,
        CLS_BEQ,
        CLS_HALT,
        CLS_ILLEGAL
    } instr_class_t;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
        logic       pc_write;
        logic       ir_write;
        logic       halted;
    } ctrl_t;

    // Immediate ALU ops occupy the whole 01xx block.
    function automatic instr_class_t decode_opcode(input logic [3:0] op);
        instr_class_t cls;
        cls = CLS_ILLEGAL;
        case (op)
            OP_RTYPE:                              cls = CLS_RTYPE;
            4'b0100, 4'b0101, 4'b0110, 4'b0111:    cls = CLS_IMM;
            OP_LW, OP_SW:                          cls = CLS_MEM;
            OP_BEQ:                                cls = CLS_BEQ;
            OP_HALT:                               cls = CLS_HALT;
            default:                               cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/control_outputs.sv
// Moore decode of the controller state into the datapath control word.
module control_outputs
    import multicycle_control_pkg::*;
(
    input  state_t i_state,
    output ctrl_t  o_ctrl
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a field unassigned, which would otherwise infer a latch.
        o_ctrl = '0;
        case (i_state)
            ST_FETCH: begin
                o_ctrl.ir_write = 1'b1;
                o_ctrl.pc_write = 1'b1;
            end
            ST_DECODE: ;
            ST_EX_R: begin
                o_ctrl.alu_op = ALUOP_FUNCT;
            end
            ST_WB_R: begin
                o_ctrl.alu_op    = ALUOP_FUNCT;
                o_ctrl.reg_dst   = 1'b1;
                o_ctrl.reg_write = 1'b1;
            end
            ST_EX_I: begin
                o_ctrl.alu_src = 1'b1;
                o_ctrl.alu_op  = ALUOP_IMM;
            end
            ST_WB_I: begin
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.alu_op    = ALUOP_IMM;
                o_ctrl.reg_write = 1'b1;
            end
            ST_MEM_ADDR: begin
                o_ctrl.alu_src = 1'b1;
                o_ctrl.alu_op  = ALUOP_ADD;
            end
            ST_MEM_RD: begin
                o_ctrl.alu_src  = 1'b1;
                o_ctrl.mem_read = 1'b1;
            end
            ST_WB_MEM: begin
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_write  = 1'b1;
            end
            ST_MEM_WR: begin
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.mem_write = 1'b1;
            end
            ST_BRANCH: begin
                o_ctrl.alu_op = ALUOP_SUB;
                o_ctrl.branch = 1'b1;
            end
            ST_HALT: begin
                o_ctrl.halted = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle instruction controller: state register, next-state dispatch and
// retired-instruction counter; control decode lives in control_outputs.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic [3:0]  opcode,
    input  logic        MemReady,
    output logic        RegDst,
    output logic        AluSrc,
    output logic        MemToReg,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Branch,
    output logic [1:0]  AluOp,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        Halted,
    output logic [3:0]  State,
    output logic [15:0] InstrCount
);

    state_t       r_state;
    state_t       w_next_state;
    logic [15:0]  r_instr_count;
    logic         w_retire;
    instr_class_t w_class;
    ctrl_t        w_ctrl;

    assign w_class = decode_opcode(opcode);

    always_comb begin
        w_next_state = ST_FETCH;
        w_retire     = 1'b0;
        case (r_state)
            ST_FETCH: w_next_state = ST_DECODE;
            ST_DECODE: begin
                case (w_class)
                    CLS_RTYPE: w_next_state = ST_EX_R;
                    CLS_IMM:   w_next_state = ST_EX_I;
                    CLS_MEM:   w_next_state = ST_MEM_ADDR;
                    CLS_BEQ:   w_next_state = ST_BRANCH;
                    default:   w_next_state = ST_HALT;
                endcase
            end
            ST_EX_R: w_next_state = ST_WB_R;
            ST_EX_I: w_next_state = ST_WB_I;
            // The IR still holds the load/store, so re-reading opcode picks the access type.
            ST_MEM_ADDR: w_next_state = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   w_next_state = MemReady ? ST_WB_MEM : ST_MEM_RD;
            ST_MEM_WR: begin
                w_next_state = MemReady ? ST_FETCH : ST_MEM_WR;
                w_retire     = MemReady;
            end
            ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH: begin
                w_next_state = ST_FETCH;
                w_retire     = 1'b1;
            end
            ST_HALT: w_next_state = ST_HALT;
            default: w_next_state = ST_FETCH;
        endcase
    end

    always_ff @(posedge Clock) begin
        // NOTE: synchronous reset clears only this controller's own state; the
        // datapath registers it steers are deliberately untouched.
        if (Reset) begin
            r_state       <= ST_FETCH;
            r_instr_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_retire) begin
                r_instr_count <= r_instr_count + 16'd1;
            end
        end
    end

    control_outputs u_control_outputs (
        .i_state (r_state),
        .o_ctrl  (w_ctrl)
    );

    assign RegDst     = w_ctrl.reg_dst;
    assign AluSrc     = w_ctrl.alu_src;
    assign MemToReg   = w_ctrl.mem_to_reg;
    assign RegWrite   = w_ctrl.reg_write;
    assign MemRead    = w_ctrl.mem_read;
    assign MemWrite   = w_ctrl.mem_write;
    assign Branch     = w_ctrl.branch;
    assign AluOp      = w_ctrl.alu_op;
    assign PCWrite    = w_ctrl.pc_write;
    assign IRWrite    = w_ctrl.ir_write;
    assign Halted     = w_ctrl.halted;
    assign State      = r_state;
    assign InstrCount = r_instr_count;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle by
// cycle and compares state, controls and InstrCount against hand-written values.
module tb_multicycle_control;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EX_R     = 4'd2;
    localparam logic [3:0] S_WB_R     = 4'd3;
    localparam logic [3:0] S_EX_I     = 4'd4;
    localparam logic [3:0] S_WB_I     = 4'd5;
    localparam logic [3:0] S_MEM_ADDR = 4'd6;
    localparam logic [3:0] S_MEM_RD   = 4'd7;
    localparam logic [3:0] S_WB_MEM   = 4'd8;
    localparam logic [3:0] S_MEM_WR   = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_HALT     = 4'd11;

    logic        Clock;
    logic        Reset;
    logic [3:0]  opcode;
    logic        MemReady;
    logic        RegDst, AluSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch;
    logic [1:0]  AluOp;
    logic        PCWrite, IRWrite, Halted;
    logic [3:0]  State;
    logic [15:0] InstrCount;

    int n_checks = 0;
    int n_fails  = 0;

    multicycle_control dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .opcode     (opcode),
        .MemReady   (MemReady),
        .RegDst     (RegDst),
        .AluSrc     (AluSrc),
        .MemToReg   (MemToReg),
        .RegWrite   (RegWrite),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Branch     (Branch),
        .AluOp      (AluOp),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .Halted     (Halted),
        .State      (State),
        .InstrCount (InstrCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // {RegDst,AluSrc,MemToReg,RegWrite,MemRead,MemWrite,Branch,AluOp,PCWrite,IRWrite,Halted}
    logic [11:0] w_ctrl;
    assign w_ctrl = {RegDst, AluSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch,
                     AluOp, PCWrite, IRWrite, Halted};

    function automatic logic [11:0] exp_ctrl(input logic [3:0] st);
        logic [11:0] v;
        case (st)
            S_FETCH:    v = 12'b0000000_00_110;
            S_DECODE:   v = 12'b0000000_00_000;
            S_EX_R:     v = 12'b0000000_10_000;
            S_WB_R:     v = 12'b1001000_10_000;
            S_EX_I:     v = 12'b0100000_11_000;
            S_WB_I:     v = 12'b0101000_11_000;
            S_MEM_ADDR: v = 12'b0100000_00_000;
            S_MEM_RD:   v = 12'b0100100_00_000;
            S_WB_MEM:   v = 12'b0111000_00_000;
            S_MEM_WR:   v = 12'b0100010_00_000;
            S_BRANCH:   v = 12'b0000001_01_000;
            S_HALT:     v = 12'b0000000_00_001;
            default:    v = 12'b0000000_00_000;
        endcase
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Compare state and controls at this negedge, then advance one cycle.
    task automatic cycle(input string tag, input logic [3:0] exp_state);
        check({tag, ".state"}, 32'(State), 32'(exp_state));
        check({tag, ".ctrl"}, 32'(w_ctrl), 32'(exp_ctrl(exp_state)));
        @(negedge Clock);
    endtask

    task automatic check_count(input string tag, input logic [15:0] exp);
        check({tag, ".count"}, 32'(InstrCount), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset    = 1'b1;
        opcode   = 4'b0000;
        MemReady = 1'b1;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;

        // R-type: 4 cycles, one retirement
        check_count("reset", 16'd0);
        cycle("r_fetch", S_FETCH);
        cycle("r_decode", S_DECODE);
        opcode = 4'b1111;
        cycle("r_ex", S_EX_R);
        cycle("r_wb", S_WB_R);
        check_count("r_done", 16'd1);

        // LW with MemReady low for three MEM_RD cycles: 8 cycles total
        opcode   = 4'b1000;
        MemReady = 1'b0;
        cycle("lw_fetch", S_FETCH);
        cycle("lw_decode", S_DECODE);
        cycle("lw_addr", S_MEM_ADDR);
        opcode = 4'b1100;
        cycle("lw_rd1", S_MEM_RD);
        cycle("lw_rd2", S_MEM_RD);
        cycle("lw_rd3", S_MEM_RD);
        MemReady = 1'b1;
        cycle("lw_rd4", S_MEM_RD);
        cycle("lw_wb", S_WB_MEM);
        check_count("lw_done", 16'd2);

        // SW with MemReady=1: 4 cycles, no RegWrite anywhere
        opcode = 4'b1100;
        cycle("sw_fetch", S_FETCH);
        cycle("sw_decode", S_DECODE);
        cycle("sw_addr", S_MEM_ADDR);
        cycle("sw_wr", S_MEM_WR);
        check_count("sw_done", 16'd3);

        // Immediate ALU, opcode changes after DECODE are ignored
        opcode = 4'b0101;
        cycle("imm_fetch", S_FETCH);
        cycle("imm_decode", S_DECODE);
        opcode = 4'b1000;
        cycle("imm_ex", S_EX_I);
        cycle("imm_wb", S_WB_I);
        check_count("imm_done", 16'd4);

        // SW stalled one cycle: no retirement until MemReady
        opcode = 4'b1100;
        cycle("sw2_fetch", S_FETCH);
        cycle("sw2_decode", S_DECODE);
        MemReady = 1'b0;
        cycle("sw2_addr", S_MEM_ADDR);
        cycle("sw2_wr1", S_MEM_WR);
        check_count("sw2_stall", 16'd4);
        MemReady = 1'b1;
        cycle("sw2_wr2", S_MEM_WR);
        check_count("sw2_done", 16'd5);

        // BEQ: 3 cycles
        opcode = 4'b0010;
        cycle("beq_fetch", S_FETCH);
        cycle("beq_decode", S_DECODE);
        cycle("beq_br", S_BRANCH);
        check_count("beq_done", 16'd6);

        // Reset in EX_I clears state and count
        opcode = 4'b0110;
        cycle("rsti_fetch", S_FETCH);
        cycle("rsti_decode", S_DECODE);
        Reset = 1'b1;
        cycle("rsti_ex", S_EX_I);
        Reset = 1'b0;
        check_count("rsti_after", 16'd0);

        // BEQ then illegal opcode 1010 into HALT for 20 cycles
        opcode = 4'b0010;
        cycle("beq2_fetch", S_FETCH);
        cycle("beq2_decode", S_DECODE);
        cycle("beq2_br", S_BRANCH);
        opcode = 4'b1010;
        cycle("ill_fetch", S_FETCH);
        cycle("ill_decode", S_DECODE);
        opcode = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            MemReady = i[0];
            cycle("ill_halt", S_HALT);
        end
        check_count("ill_halt", 16'd1);
        Reset = 1'b1;
        cycle("rsth_halt", S_HALT);
        Reset = 1'b0;
        check_count("rsth_after", 16'd0);
        MemReady = 1'b1;

        // HALT opcode
        opcode = 4'b1111;
        cycle("hlt_fetch", S_FETCH);
        cycle("hlt_decode", S_DECODE);
        for (int i = 0; i < 3; i++) cycle("hlt_halt", S_HALT);
        check_count("hlt_halt", 16'd0);
        Reset = 1'b1;
        cycle("rsth2_halt", S_HALT);
        Reset = 1'b0;

        // Counter wrap: preload 0xFFFE, then two BEQs
        opcode = 4'b0010;
        force dut.r_instr_count = 16'hFFFE;
        cycle("wrap_fetch1", S_FETCH);
        release dut.r_instr_count;
        cycle("wrap_decode1", S_DECODE);
        check_count("wrap_pre", 16'hFFFE);
        cycle("wrap_br1", S_BRANCH);
        check_count("wrap_ffff", 16'hFFFF);
        cycle("wrap_fetch2", S_FETCH);
        cycle("wrap_decode2", S_DECODE);
        cycle("wrap_br2", S_BRANCH);
        check_count("wrap_zero", 16'h0000);
        cycle("wrap_fetch3", S_FETCH);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port Clock, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 Port Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port opcode, input, 4 bits: instruction[15:12] from the datapath instruction register.
REQ-005 Port MemReady, input, 1 bit: data memory has completed the current read or write access.
REQ-006 Outputs RegDst, AluSrc, MemToReg, RegWrite, MemRead, MemWrite and Branch, 1 bit each: datapath controls with the existing meanings.
REQ-007 Output AluOp, 2 bits: 00 = add, 01 = subtract (compare), 10 = R-type funct, 11 = immediate opcode-based.
REQ-008 Output PCWrite, 1 bit: load PC with PC+2.
REQ-009 Output IRWrite, 1 bit: latch the instruction register.
REQ-010 Output Halted, 1 bit: the core is stopped.
REQ-011 Output State, 4 bits: current state encoding, for debug.
REQ-012 Output InstrCount, 16 bits: count of retired instructions.

Function
REQ-013 Opcode decode SHALL be:
- 0000 = R-type
- 0100 to 0111 = immediate ALU
- 1000 = LW
- 1100 = SW
- 0010 = BEQ
- 1111 = HALT
- every other value = illegal.
REQ-014 States SHALL be FETCH, DECODE, EX_R, WB_R, EX_I, WB_I, MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH and HALT.
REQ-015 State transitions SHALL be:
- FETCH goes to DECODE.
- DECODE dispatches on opcode: R-type to EX_R, immediate to EX_I, LW/SW to MEM_ADDR, BEQ to BRANCH, HALT or illegal to HALT.
- EX_R goes to WB_R; EX_I goes to WB_I.
- MEM_ADDR goes to MEM_RD for LW, or to MEM_WR for SW.
- WB_R, WB_I, WB_MEM, MEM_WR and BRANCH all go to FETCH.
REQ-016 MEM_RD and MEM_WR SHALL hold while MemReady=0; MEM_RD advances to WB_MEM, and MEM_WR to FETCH, in the cycle after MemReady=1 is sampled.
REQ-017 The HALT state SHALL be absorbing; only Reset leaves it.
REQ-018 Outputs SHALL be Moore (decoded from state only); every signal not listed for a state below is 0:
- FETCH: IRWrite=1, PCWrite=1.
- DECODE: all controls 0.
- EX_R: AluOp=10.
- WB_R: AluOp=10, RegDst=1, RegWrite=1.
- EX_I: AluSrc=1, AluOp=11.
- WB_I: AluSrc=1, AluOp=11, RegWrite=1.
- MEM_ADDR: AluSrc=1, AluOp=00.
- MEM_RD: AluSrc=1, MemRead=1.
- WB_MEM: AluSrc=1, MemToReg=1, RegWrite=1.
- MEM_WR: AluSrc=1, MemWrite=1.
- BRANCH: AluOp=01, Branch=1.
- HALT: Halted=1.
REQ-019 Latency with MemReady=1 SHALL be: R-type 4 cycles, immediate 4, LW 5, SW 4, BEQ 3; each cycle of MemReady=0 adds one cycle.
REQ-020 InstrCount SHALL increment by 1 on each transition out of WB_R, WB_I, WB_MEM, MEM_WR or BRANCH.
REQ-021 InstrCount SHALL wrap from 0xFFFF to 0x0000.
REQ-022 Entering HALT SHALL NOT increment InstrCount.
REQ-023 opcode SHALL be sampled only in DECODE and MEM_ADDR; changes in opcode during any other state SHALL be ignored.

Reset
REQ-024 Reset=1 at a rising edge SHALL force state FETCH and InstrCount=0, overriding all other inputs, including mid-instruction and in HALT.
REQ-025 In the cycle after reset, outputs SHALL be the FETCH values: IRWrite=1, PCWrite=1, all others 0, State = FETCH encoding.
REQ-026 Reset SHALL NOT affect any datapath register; this block resets only its own state.

Structure
REQ-027 The state encoding (4 bits, FETCH=0), the opcode constants and the AluOp constants SHALL live in a shared package used by this block and by AluControl.
REQ-028 The state-to-control decode SHALL be one combinational sub-module named control_outputs; the state register, next-state logic and counter SHALL stay in multicycle_control.

Verification
REQ-029 Reset, then opcode=0000 with MemReady=1 -> states FETCH,DECODE,EX_R,WB_R,FETCH; WB_R shows RegDst=1, RegWrite=1, AluOp=10; InstrCount=1.
REQ-030 opcode=1000 with MemReady low for 3 cycles in MEM_RD -> MemRead=1 held 4 cycles, WB_MEM shows MemToReg=1, RegWrite=1, total 8 cycles.
REQ-031 opcode=1100, MemReady=1 -> MEM_WR shows MemWrite=1 for 1 cycle, RegWrite never 1, return to FETCH after 4 cycles.
REQ-032 opcode=0010 -> BRANCH shows Branch=1, AluOp=01 for 1 cycle; opcode=1111 or 1010 -> HALT, Halted=1 held 20 cycles, InstrCount unchanged.
REQ-033 Reset asserted in EX_I and again in HALT -> next state FETCH and InstrCount=0 in both cases.
REQ-034 Force InstrCount to 0xFFFF via 65535 BEQ instructions, then one more -> InstrCount=0x0000.
